// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Brief    : Direct-mapped BHT (saturating counters) + tagged BTB with
//            combinational lookup and saturating branch/mispredict statistics.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic [31:0]       i_if_pc,
    output logic              o_pred_hit,
    output logic              o_pred_taken,
    output logic [31:0]       o_pred_target,
    input  logic              i_upd_valid,
    input  logic [31:0]       i_upd_pc,
    input  logic              i_upd_taken,
    input  logic [31:0]       i_upd_target,
    input  logic              i_upd_mispredicted,
    output logic [CNT_W-1:0]  o_branch_cnt,
    output logic [CNT_W-1:0]  o_mispredict_cnt
);

    localparam int                c_ENTRIES  = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] c_WT      = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] c_WNT     = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] c_CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] c_CTR_ONE = CTR_BITS'(1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0]    c_CNT_ONE = CNT_W'(1);

    generate
        if (INDEX_BITS + TAG_BITS + 2 > 32) begin : g_param_check
            $error("branch_predictor: INDEX_BITS+TAG_BITS+2 must not exceed 32");
        end
    endgenerate

    logic                  r_valid  [c_ENTRIES];
    logic [TAG_BITS-1:0]   r_tag    [c_ENTRIES];
    logic [CTR_BITS-1:0]   r_ctr    [c_ENTRIES];
    logic [31:0]           r_target [c_ENTRIES];
    logic [CNT_W-1:0]      r_branch_cnt;
    logic [CNT_W-1:0]      r_mispredict_cnt;

    logic [INDEX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0]   w_if_tag;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]   w_upd_tag;
    logic                  w_if_hit;
    logic                  w_if_taken;
    logic                  w_upd_hit;
    logic [31:0]           w_pc_plus4;

    assign w_if_idx   = i_if_pc[INDEX_BITS+1:2];
    assign w_if_tag   = i_if_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign w_upd_idx  = i_upd_pc[INDEX_BITS+1:2];
    assign w_upd_tag  = i_upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign w_pc_plus4 = i_if_pc + 32'd4;

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign w_if_hit   = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_if_taken = i_enable && w_if_hit && r_ctr[w_if_idx][CTR_BITS-1];
    assign w_upd_hit  = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    assign o_pred_hit    = w_if_hit;
    assign o_pred_taken  = w_if_taken;
    assign o_pred_target = w_if_taken ? r_target[w_if_idx] : w_pc_plus4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= c_WNT;
                r_target[i] <= '0;
            end
        end else if (i_upd_valid) begin
            if (w_upd_hit) begin
                if (i_upd_taken) begin
                    if (r_ctr[w_upd_idx] != c_CTR_MAX) begin
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + c_CTR_ONE;
                    end
                    r_target[w_upd_idx] <= i_upd_target;
                end else if (r_ctr[w_upd_idx] != '0) begin
                    r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - c_CTR_ONE;
                end
            end else if (i_upd_taken) begin
                // Allocation on a taken miss evicts any aliasing entry.
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_ctr[w_upd_idx]    <= c_WT;
                r_target[w_upd_idx] <= i_upd_target;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (i_upd_valid) begin
            if (r_branch_cnt != c_CNT_MAX) begin
                r_branch_cnt <= r_branch_cnt + c_CNT_ONE;
            end
            if (i_upd_mispredicted && (r_mispredict_cnt != c_CNT_MAX)) begin
                r_mispredict_cnt <= r_mispredict_cnt + c_CNT_ONE;
            end
        end
    end

    assign o_branch_cnt     = r_branch_cnt;
    assign o_mispredict_cnt = r_mispredict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Directed scoreboard bench for branch_predictor (CNT_W=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    localparam int c_CNT_W = 4;

    logic               clk;
    logic               reset;
    logic               i_enable;
    logic [31:0]        i_if_pc;
    logic               o_pred_hit;
    logic               o_pred_taken;
    logic [31:0]        o_pred_target;
    logic               i_upd_valid;
    logic [31:0]        i_upd_pc;
    logic               i_upd_taken;
    logic [31:0]        i_upd_target;
    logic               i_upd_mispredicted;
    logic [c_CNT_W-1:0] o_branch_cnt;
    logic [c_CNT_W-1:0] o_mispredict_cnt;

    branch_predictor #(
        .INDEX_BITS (6),
        .TAG_BITS   (8),
        .CTR_BITS   (2),
        .CNT_W      (c_CNT_W)
    ) u_dut (
        .clk                (clk),
        .reset              (reset),
        .i_enable           (i_enable),
        .i_if_pc            (i_if_pc),
        .o_pred_hit         (o_pred_hit),
        .o_pred_taken       (o_pred_taken),
        .o_pred_target      (o_pred_target),
        .i_upd_valid        (i_upd_valid),
        .i_upd_pc           (i_upd_pc),
        .i_upd_taken        (i_upd_taken),
        .i_upd_target       (i_upd_target),
        .i_upd_mispredicted (i_upd_mispredicted),
        .o_branch_cnt       (o_branch_cnt),
        .o_mispredict_cnt   (o_mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string              name;
        int                 cyc;
        logic               hit;
        logic               taken;
        logic [31:0]        tgt;
        bit                 chk_cnt;
        logic [c_CNT_W-1:0] bcnt;
        logic [c_CNT_W-1:0] mcnt;
    } exp_t;

    exp_t q_exp[$];
    int   cyc    = 0;
    int   tests  = 0;
    int   failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (q_exp.size() > 0 && q_exp[0].cyc == cyc) begin
            exp_t e;
            e = q_exp.pop_front();
            tests++;
            if (o_pred_hit !== e.hit || o_pred_taken !== e.taken || o_pred_target !== e.tgt ||
                (e.chk_cnt && (o_branch_cnt !== e.bcnt || o_mispredict_cnt !== e.mcnt))) begin
                failed++;
                $display("FAIL %s: got hit=%b taken=%b tgt=%h bcnt=%0d mcnt=%0d, want hit=%b taken=%b tgt=%h bcnt=%0d mcnt=%0d (cnt checked=%0d)",
                         e.name, o_pred_hit, o_pred_taken, o_pred_target, o_branch_cnt, o_mispredict_cnt,
                         e.hit, e.taken, e.tgt, e.bcnt, e.mcnt, e.chk_cnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt, input logic um);
        i_if_pc            = pc;
        i_upd_valid        = uv;
        i_upd_pc           = upc;
        i_upd_taken        = ut;
        i_upd_target       = utgt;
        i_upd_mispredicted = um;
    endtask

    task automatic expect_now(input string name, input logic hit, input logic taken,
                              input logic [31:0] tgt, input bit chk,
                              input int b, input int m);
        exp_t e;
        e.name    = name;
        e.cyc     = cyc;
        e.hit     = hit;
        e.taken   = taken;
        e.tgt     = tgt;
        e.chk_cnt = chk;
        e.bcnt    = c_CNT_W'(b);
        e.mcnt    = c_CNT_W'(m);
        q_exp.push_back(e);
    endtask

    initial begin
        reset    = 1'b1;
        i_enable = 1'b1;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (3) step();
        reset = 1'b0;

        // Reset state and first allocation (mispredicted, so mcnt counts it)
        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_now("reset_lookup", 1'b0, 1'b0, 32'h44, 1, 0, 0);
        step();
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1);
        expect_now("alloc_same_cycle", 1'b0, 1'b0, 32'h44, 1, 0, 0);
        step();
        drive(32'h40, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1);
        expect_now("alloc_visible", 1'b1, 1'b1, 32'h100, 1, 1, 1);

        // Counter walk: 2 -> 1 -> 0 -> 0 -> 1 -> 2 -> 3 -> 3 -> 2
        step();
        drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        expect_now("ctr2", 1'b1, 1'b1, 32'h100, 1, 1, 1);
        step();
        expect_now("ctr1", 1'b1, 1'b0, 32'h44, 1, 2, 1);
        step();
        expect_now("ctr0", 1'b1, 1'b0, 32'h44, 1, 3, 1);
        step();
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
        expect_now("ctr0_sat", 1'b1, 1'b0, 32'h44, 1, 4, 1);
        step();
        expect_now("ctr1_up", 1'b1, 1'b0, 32'h44, 1, 5, 1);
        step();
        expect_now("ctr2_up", 1'b1, 1'b1, 32'h100, 1, 6, 1);
        step();
        expect_now("ctr3_up", 1'b1, 1'b1, 32'h100, 1, 7, 1);
        step();
        drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        expect_now("ctr3_sat", 1'b1, 1'b1, 32'h100, 1, 8, 1);
        step();
        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_now("ctr3_down", 1'b1, 1'b1, 32'h100, 1, 9, 1);

        // Aliasing and no allocation on not-taken miss
        step();
        drive(32'h140, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0);
        expect_now("alias_miss", 1'b0, 1'b0, 32'h144, 1, 9, 1);
        step();
        drive(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_now("alias_alloc", 1'b1, 1'b1, 32'h200, 1, 10, 1);
        step();
        drive(32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        expect_now("alias_evicted", 1'b0, 1'b0, 32'h44, 1, 10, 1);
        step();
        drive(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_now("nt_no_alloc", 1'b0, 1'b0, 32'h84, 1, 11, 1);

        // Same-cycle lookup/update, then legacy mode, then PC wrap
        step();
        drive(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0);
        expect_now("same_cycle_pre", 1'b0, 1'b0, 32'h84, 1, 11, 1);
        step();
        drive(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_now("same_cycle_post", 1'b1, 1'b1, 32'h300, 1, 12, 1);
        step();
        i_enable = 1'b0;
        expect_now("legacy_mode", 1'b1, 1'b0, 32'h84, 1, 12, 1);
        step();
        i_enable = 1'b1;
        i_if_pc  = 32'hFFFF_FFFC;
        expect_now("pc_wrap", 1'b0, 1'b0, 32'h0000_0000, 1, 12, 1);

        // Reset with an update presented: cleared immediately, update dropped
        step();
        reset = 1'b1;
        drive(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b1);
        expect_now("reset_clears", 1'b0, 1'b0, 32'h84, 1, 0, 0);
        step();
        reset = 1'b0;
        drive(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_now("reset_drops_upd", 1'b0, 1'b0, 32'h84, 1, 0, 0);

        // 20 updates, 3 mispredicted: branch count saturates at 15
        for (int i = 0; i < 20; i++) begin
            step();
            drive(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, (i == 0 || i == 5 || i == 10));
            if (i == 1) expect_now("stat_first", 1'b1, 1'b1, 32'h300, 1, 1, 1);
            if (i == 16) expect_now("stat_mid", 1'b1, 1'b1, 32'h300, 1, 15, 3);
        end
        step();
        drive(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_now("stat_sat", 1'b1, 1'b1, 32'h300, 1, 15, 3);

        // Mid-cycle asynchronous reset
        step();
        reset = 1'b1;
        expect_now("midrun_reset", 1'b0, 1'b0, 32'h84, 1, 0, 0);
        step();
        reset = 1'b0;

        repeat (3) step();
        if (q_exp.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expectations unchecked, want 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
